// File: rtl/colour_conv_pkg.sv
// Shared definitions for the colour conversion datapath: packer FSM state
// encoding, frame/address defaults and the packed pixel layout.
package colour_conv_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned PIX_W  = 24;

  localparam int unsigned         PIXELS_DEFAULT = 38400;
  localparam logic [ADDR_W-1:0]   WBASE_DEFAULT  = 18'd115200;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_W1   = 3'd2,
    ST_W2   = 3'd3,
    ST_FIN  = 3'd4
  } pack_state_e;

  // One clipped pixel as it sits in the FIFO and holding register.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

endpackage

// File: rtl/rgb_pixel_fifo.sv
// Pixel FIFO: one push port, a dual-pop port that removes the two oldest
// entries in one cycle, and an occupancy count. DEPTH must be a power of two
// so the pointers wrap on their own. The caller guarantees no push when full
// and no pop2 with fewer than two entries.
module rgb_pixel_fifo
  import colour_conv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = PIX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop2_i,
  output logic [W-1:0]             pop_data0_o,
  output logic [W-1:0]             pop_data1_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_nx;
  logic [CNT_W-1:0] count_q;

  assign rd_ptr_nx   = rd_ptr_q + 1'b1;
  assign pop_data0_o = mem_q[rd_ptr_q];
  assign pop_data1_o = mem_q[rd_ptr_nx];
  assign count_o     = count_q;

  // Storage write; contents are only meaningful under the count.
  // NOTE: the data array has no reset -- validity comes from the pointers and
  // count, so resetting it would only add reset fan-out for no behaviour.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy bookkeeping; push and pop2 may coincide.
  // NOTE: non-blocking assignments in every clocked block, so all registers
  // update from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop2_i) rd_ptr_q <= rd_ptr_q + PTR_W'(2);
      count_q <= count_q + CNT_W'(push_i) - (pop2_i ? CNT_W'(2) : '0);
    end
  end

endmodule

// File: rtl/rgb_pack_writer.sv
// RGB pack writer: clips converted pixels to 8 bits, buffers them, packs each
// pixel pair into three 16-bit SRAM words issued only in granted write slots,
// and flags end_of_pixel once the frame's last word is written.
// Build option: define RGB_PACK_CLIP_EN for saturating clip; otherwise each
// component is truncated to its low 8 bits.
module rgb_pack_writer
  import colour_conv_pkg::*;
#(
  parameter int unsigned       PIXELS = PIXELS_DEFAULT,
  parameter logic [ADDR_W-1:0] WBASE  = WBASE_DEFAULT,
  parameter int unsigned       DEPTH  = 4,
  parameter int unsigned       IW     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [IW-1:0] in_r,
  input  logic signed [IW-1:0] in_g,
  input  logic signed [IW-1:0] in_b,
  input  logic                 wr_slot,
  output logic                 sram_we,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [15:0]          sram_wdata,
  output logic                 end_of_pixel
);

  localparam int unsigned      CW        = $clog2(PIXELS + 1);
  localparam logic [CW-1:0]    PIX_LAST  = CW'(PIXELS);
  localparam int unsigned      FCW       = $clog2(DEPTH) + 1;
  localparam logic [FCW-1:0]   FIFO_FULL = FCW'(DEPTH);

  // Reduce a signed conversion result to one 8-bit colour component.
  function automatic logic [7:0] to_u8(input logic signed [IW-1:0] x);
`ifdef RGB_PACK_CLIP_EN
    if (x[IW-1])          return 8'h00;
    else if (|x[IW-2:8])  return 8'hFF;
    else                  return x[7:0];
`else
    return x[7:0];
`endif
  endfunction

  rgb8_t            push_px;
  logic             push;
  logic             load;
  logic [FCW-1:0]   fifo_count;
  logic [PIX_W-1:0] pop0;
  logic [PIX_W-1:0] pop1;

  logic [CW-1:0]     acc_cnt_q;
  logic [CW-1:0]     done_cnt_q;
  pack_state_e       state_q;
  rgb8_t             pix_a_q;
  rgb8_t             pix_b_q;
  logic [ADDR_W-1:0] next_addr_q;
  logic              sram_we_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [15:0]       sram_wdata_q;
  logic              eop_q;

  assign push_px.r = to_u8(in_r);
  assign push_px.g = to_u8(in_g);
  assign push_px.b = to_u8(in_b);

  // Accept while there is FIFO room and the frame is not yet fully accepted;
  // start wins over a coincident push or pair load.
  assign in_ready = (fifo_count != FIFO_FULL) && (acc_cnt_q != PIX_LAST);
  assign push     = in_valid && in_ready && !start;
  // The holding register is free exactly while the packer is IDLE.
  assign load     = (state_q == ST_IDLE) && (fifo_count >= FCW'(2)) && !start;

  rgb_pixel_fifo #(
    .DEPTH (DEPTH),
    .W     (PIX_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .clear_i     (start),
    .push_i      (push),
    .push_data_i (push_px),
    .pop2_i      (load),
    .pop_data0_o (pop0),
    .pop_data1_o (pop1),
    .count_o     (fifo_count)
  );

  // Frame accept counter driving the input cut-off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        acc_cnt_q <= '0;
    else if (start)  acc_cnt_q <= '0;
    else if (push)   acc_cnt_q <= acc_cnt_q + 1'b1;
  end

  // Packer FSM: load a pair, emit three words in granted slots, finish frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pix_a_q      <= '0;
      pix_b_q      <= '0;
      next_addr_q  <= WBASE;
      done_cnt_q   <= '0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= WBASE;
      sram_wdata_q <= '0;
      eop_q        <= 1'b0;
    end else if (start) begin
      state_q      <= ST_IDLE;
      pix_a_q      <= '0;
      pix_b_q      <= '0;
      next_addr_q  <= WBASE;
      done_cnt_q   <= '0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= WBASE;
      sram_wdata_q <= '0;
      eop_q        <= 1'b0;
    end else begin
      sram_we_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (load) begin
            pix_a_q <= rgb8_t'(pop0);
            pix_b_q <= rgb8_t'(pop1);
            state_q <= ST_W0;
          end
        end
        ST_W0, ST_W1, ST_W2: begin
          if (wr_slot) begin
            sram_we_q   <= 1'b1;
            sram_addr_q <= next_addr_q;
            next_addr_q <= next_addr_q + 1'b1;
            if (state_q == ST_W0) begin
              sram_wdata_q <= {pix_a_q.r, pix_a_q.g};
              state_q      <= ST_W1;
            end else if (state_q == ST_W1) begin
              sram_wdata_q <= {pix_a_q.b, pix_b_q.r};
              state_q      <= ST_W2;
            end else begin
              sram_wdata_q <= {pix_b_q.g, pix_b_q.b};
              done_cnt_q   <= done_cnt_q + CW'(2);
              if (done_cnt_q + CW'(2) == PIX_LAST) begin
                state_q <= ST_FIN;
                eop_q   <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_FIN;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sram_we      = sram_we_q;
  assign sram_addr    = sram_addr_q;
  assign sram_wdata   = sram_wdata_q;
  assign end_of_pixel = eop_q;

endmodule

// File: tb/tb_rgb_pack_writer.sv
// Directed bench for rgb_pack_writer with a write scoreboard: expected SRAM
// words are queued as pixels are accepted and compared as writes appear.
module tb_rgb_pack_writer;

  localparam int unsigned PIXELS = 8;
  localparam logic [17:0] WBASE  = 18'd115200;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned IW     = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [IW-1:0] in_r = '0;
  logic signed [IW-1:0] in_g = '0;
  logic signed [IW-1:0] in_b = '0;
  logic                 wr_slot = 1'b0;
  logic                 sram_we;
  logic [17:0]          sram_addr;
  logic [15:0]          sram_wdata;
  logic                 end_of_pixel;

  rgb_pack_writer #(
    .PIXELS (PIXELS),
    .WBASE  (WBASE),
    .DEPTH  (DEPTH),
    .IW     (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_r         (in_r),
    .in_g         (in_g),
    .in_b         (in_b),
    .wr_slot      (wr_slot),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .end_of_pixel (end_of_pixel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
    logic        eop;
  } wr_t;

  wr_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  pend_r, pend_g, pend_b;
  bit          have_pend = 0;
  int unsigned model_px = 0;
  logic [17:0] exp_addr = WBASE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    sb_q.delete();
    have_pend = 0;
    model_px  = 0;
    exp_addr  = WBASE;
  endtask

  // Reference packing of an accepted (already 8-bit) pixel stream.
  task automatic model_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    wr_t e;
    model_px++;
    if (!have_pend) begin
      pend_r = r; pend_g = g; pend_b = b;
      have_pend = 1;
    end else begin
      e.addr = exp_addr;       e.data = {pend_r, pend_g}; e.eop = 1'b0;
      sb_q.push_back(e);
      e.addr = exp_addr + 18'd1; e.data = {pend_b, r};    e.eop = 1'b0;
      sb_q.push_back(e);
      e.addr = exp_addr + 18'd2; e.data = {g, b};         e.eop = (model_px == PIXELS);
      sb_q.push_back(e);
      exp_addr  = exp_addr + 18'd3;
      have_pend = 0;
    end
  endtask

  // Offer one pixel until accepted (bounded); optionally feed the model.
  task automatic send(input int r, input int g, input int b,
                      input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                      input bit do_model = 1);
    bit ok = 0;
    in_r = IW'(r); in_g = IW'(g); in_b = IW'(b);
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    in_valid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
    if (ok && do_model) model_pixel(er, eg, eb);
  endtask

  // Grant every slot until the scoreboard empties (bounded).
  task automatic drain();
    wr_slot = 1'b1;
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
    wr_slot = 1'b0;
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_clear();
  endtask

  // Scoreboard monitor: every write must match the oldest expected word.
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b1 && sram_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("write_expected", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", 32'(sram_addr), 32'(e.addr));
        check("wr_data", 32'(sram_wdata), 32'(e.data));
        check("wr_eop",  32'(end_of_pixel), 32'(e.eop));
      end
    end
  end

  initial begin
    int idx;
    bit rdy;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_we",    32'(sram_we), 32'd0);
    check("rst_addr",  32'(sram_addr), 32'(WBASE));
    check("rst_wdata", 32'(sram_wdata), 32'd0);
    check("rst_eop",   32'(end_of_pixel), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_start();

    // Basic packing with isolated write slots.
    send(10, 20, 30, 8'd10, 8'd20, 8'd30);
    send(40, 50, 60, 8'd40, 8'd50, 8'd60);
    check("basic_w0_model", 32'(sb_q[0].data), 32'h0A14);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      wr_slot = 1'b1;
      @(posedge clk);
      #1;
      wr_slot = 1'b0;
      @(negedge clk);
      check("basic_we_hi", 32'(sram_we), 32'd1);
      @(negedge clk);
      check("basic_gap_we_lo", 32'(sram_we), 32'd0);
    end
    check("basic_sb_empty", 32'(sb_q.size()), 32'd0);

    // Clipping / truncation.
    do_start();
`ifdef RGB_PACK_CLIP_EN
    send(-5, 300, 128, 8'h00, 8'hFF, 8'h80);
    send(255, 256, -1, 8'hFF, 8'hFF, 8'h00);
`else
    send(-5, 300, 128, 8'hFB, 8'h2C, 8'h80);
    send(255, 256, -1, 8'hFF, 8'h00, 8'hFF);
`endif
    drain();

    // Backpressure: no slots, 8 pixels offered, 6 fit; then the full frame.
    do_start();
    wr_slot = 1'b0;
    idx = 0;
    in_r = IW'(1); in_g = IW'(2); in_b = IW'(255);
    in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        model_pixel(8'(idx * 16 + 1), 8'(idx * 16 + 2), 8'(255 - idx * 16));
        idx++;
        in_r = IW'(idx * 16 + 1); in_g = IW'(idx * 16 + 2); in_b = IW'(255 - idx * 16);
      end
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(idx), 32'd6);
    @(negedge clk);
    check("bp_ready_low", 32'(in_ready), 32'd0);
    check("bp_no_write", 32'(sram_we), 32'd0);
    wr_slot = 1'b1;
    send(6 * 16 + 1, 6 * 16 + 2, 255 - 6 * 16, 8'(6 * 16 + 1), 8'(6 * 16 + 2), 8'(255 - 6 * 16));
    send(7 * 16 + 1, 7 * 16 + 2, 255 - 7 * 16, 8'(7 * 16 + 1), 8'(7 * 16 + 2), 8'(255 - 7 * 16));
    drain();

    // End of frame: sticky flag, final address, no further writes or accepts.
    @(negedge clk);
    check("eof_eop",   32'(end_of_pixel), 32'd1);
    check("eof_ready", 32'(in_ready), 32'd0);
    check("eof_addr",  32'(sram_addr), 32'(WBASE + 18'd11));
    wr_slot = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("fin_no_write", 32'(sram_we), 32'd0);
    end
    wr_slot = 1'b0;

    // start clears the finished frame; start with in_valid drops the pixel.
    #1;
    do_start();
    @(negedge clk);
    check("start_eop_clr", 32'(end_of_pixel), 32'd0);
    check("start_ready",   32'(in_ready), 32'd1);
    start = 1'b1;
    in_valid = 1'b1;
    in_r = IW'(99); in_g = IW'(99); in_b = IW'(99);
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
    model_clear();
    send(1, 2, 3, 8'd1, 8'd2, 8'd3);
    send(4, 5, 6, 8'd4, 8'd5, 8'd6);
    drain();

    // Reset while the second pair sits in W1.
    do_start();
    send(7, 8, 9, 8'd7, 8'd8, 8'd9);
    send(10, 11, 12, 8'd10, 8'd11, 8'd12);
    send(13, 14, 15, 8'd0, 8'd0, 8'd0, 0);
    send(16, 17, 18, 8'd0, 8'd0, 8'd0, 0);
    drain();
    repeat (2) @(posedge clk);
    #1;
    wr_slot = 1'b1;
    @(posedge clk);
    #1;
    wr_slot = 1'b0;
    check("mid_w0_we",   32'(sram_we), 32'd1);
    check("mid_w0_addr", 32'(sram_addr), 32'(WBASE + 18'd3));
    check("mid_w0_data", 32'(sram_wdata), 32'h0D0E);
    rst = 1'b0;
    #1;
    check("mid_rst_we",    32'(sram_we), 32'd0);
    check("mid_rst_addr",  32'(sram_addr), 32'(WBASE));
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(20, 21, 22, 8'd20, 8'd21, 8'd22);
    send(23, 24, 25, 8'd23, 8'd24, 8'd25);
    drain();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
